// File: rtl/spi_arb_pkg.sv
// Shared state encoding and default sizing for the SPI byte arbiter.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StIssue = 2'b01,
      StWait  = 2'b10
   } arb_state_e;

   localparam int unsigned DataWDefault      = 8;
   localparam int unsigned TimeoutCycDefault = 1024;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request strictly after i_ptr, wrapping.
module rr_priority_pick #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned PtrW    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PtrW-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_winner,
   output logic [PtrW-1:0]    o_win_idx,
   output logic               o_valid
);

   int              cand;
   logic [PtrW-1:0] cand_idx;

   always_comb begin
      o_winner  = '0;
      o_win_idx = '0;
      o_valid   = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      // Scan farthest slot first so the nearest set request after i_ptr is the final write.
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = int'(i_ptr) + k;
         if (cand >= int'(NUM_REQ)) begin
            cand = cand - int'(NUM_REQ);
         end
         cand_idx = PtrW'(cand);
         if (i_req[cand_idx]) begin
            o_winner           = '0;
            o_winner[cand_idx] = 1'b1;
            o_win_idx          = cand_idx;
            o_valid            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_byte_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine; grant is locked for a whole frame
// and a watchdog frees the engine when a transfer never completes.
module spi_byte_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DATA_W      = DataWDefault,
   parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ*DATA_W-1:0] i_tx_byte,
   input  logic [NUM_REQ-1:0]        i_last,
   output logic [NUM_REQ-1:0]        o_gnt,
   output logic [NUM_REQ-1:0]        o_ack,
   output logic [NUM_REQ-1:0]        o_rx_valid,
   output logic [DATA_W-1:0]         o_rx_byte,
   output logic [NUM_REQ-1:0]        o_err,
   output logic                      o_spi_frame,
   output logic                      o_spi_start,
   output logic [DATA_W-1:0]         o_spi_tx_byte,
   input  logic                      i_spi_busy,
   input  logic                      i_spi_done,
   input  logic [DATA_W-1:0]         i_spi_rx_byte
);

   localparam int unsigned     PtrW   = $clog2(NUM_REQ);
   localparam int unsigned     WdW    = $clog2(TIMEOUT_CYC);
   localparam logic [WdW-1:0]  WdMax  = WdW'(TIMEOUT_CYC - 1);
   localparam logic [PtrW-1:0] PtrRst = PtrW'(NUM_REQ - 1);

   arb_state_e          state_q, state_d;
   logic [PtrW-1:0]     ptr_q, ptr_d;
   logic [PtrW-1:0]     gidx_q, gidx_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [NUM_REQ-1:0]  rx_valid_q, rx_valid_d;
   logic [NUM_REQ-1:0]  err_q, err_d;
   logic [DATA_W-1:0]   rx_byte_q, rx_byte_d;
   logic [DATA_W-1:0]   tx_byte_q, tx_byte_d;
   logic [WdW-1:0]      wd_q, wd_d;
   logic                last_q, last_d;
   logic                frame_q, frame_d;
   logic                start_q, start_d;
   logic                release_frame;

   logic [NUM_REQ-1:0]  pick_oh;
   logic [PtrW-1:0]     pick_idx;
   logic                pick_valid;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_req     (i_req),
      .i_ptr     (ptr_q),
      .o_winner  (pick_oh),
      .o_win_idx (pick_idx),
      .o_valid   (pick_valid)
   );

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      gidx_d        = gidx_q;
      gnt_d         = gnt_q;
      rx_byte_d     = rx_byte_q;
      tx_byte_d     = tx_byte_q;
      wd_d          = wd_q;
      last_d        = last_q;
      frame_d       = frame_q;
      ack_d         = '0;
      rx_valid_d    = '0;
      err_d         = '0;
      start_d       = 1'b0;
      release_frame = 1'b0;

      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               gnt_d   = pick_oh;
               gidx_d  = pick_idx;
               frame_d = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (!i_req[gidx_q]) begin
               release_frame = 1'b1;
            end else if (!i_spi_busy) begin
               start_d   = 1'b1;
               tx_byte_d = i_tx_byte[gidx_q*DATA_W +: DATA_W];
               last_d    = i_last[gidx_q];
               ack_d     = gnt_q;
               wd_d      = '0;
               state_d   = StWait;
            end
         end
         StWait: begin
            // Done is tested first so a completion on the timeout cycle is never an error.
            if (i_spi_done) begin
               rx_byte_d  = i_spi_rx_byte;
               rx_valid_d = gnt_q;
               if (last_q) begin
                  release_frame = 1'b1;
               end else begin
                  state_d = StIssue;
               end
            end else if (wd_q == WdMax) begin
               err_d         = gnt_q;
               release_frame = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (release_frame) begin
         gnt_d   = '0;
         frame_d = 1'b0;
         ptr_d   = gidx_q;
         state_d = StIdle;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StIdle;
         ptr_q      <= PtrRst;
         gidx_q     <= '0;
         gnt_q      <= '0;
         ack_q      <= '0;
         rx_valid_q <= '0;
         err_q      <= '0;
         rx_byte_q  <= '0;
         tx_byte_q  <= '0;
         wd_q       <= '0;
         last_q     <= 1'b0;
         frame_q    <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gidx_q     <= gidx_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         rx_valid_q <= rx_valid_d;
         err_q      <= err_d;
         rx_byte_q  <= rx_byte_d;
         tx_byte_q  <= tx_byte_d;
         wd_q       <= wd_d;
         last_q     <= last_d;
         frame_q    <= frame_d;
         start_q    <= start_d;
      end
   end

   assign o_gnt         = gnt_q;
   assign o_ack         = ack_q;
   assign o_rx_valid    = rx_valid_q;
   assign o_rx_byte     = rx_byte_q;
   assign o_err         = err_q;
   assign o_spi_frame   = frame_q;
   assign o_spi_start   = start_q;
   assign o_spi_tx_byte = tx_byte_q;

endmodule
